// File: rtl/stopwatch_counter.sv
// Stopwatch timebase + M.SS.t BCD counter feeding the 7-segment mux; outputs come straight from registers.
// Optional LAP_HOLD_EN macro adds a lap register that freezes the display while the count keeps running.
module stopwatch_counter #(
   parameter int TICK_DIV = 10_000_000,
   parameter int PRESC_W  = 24
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic       running,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q;
   logic [3:0]         d3_q, d2_q, d1_q, d0_q;
   logic [3:0]         d3_n, d2_n, d1_n, d0_n;
   logic               tick;
   logic               at_max;
   logic               do_clear;

   assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
   assign at_max   = (d3_q == 4'd9) && (d2_q == 4'd5) && (d1_q == 4'd9) && (d0_q == 4'd9);
   assign do_clear = clear && ((state_q == PAUSED) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_stop) state_d = RUN;
         RUN: begin
            if (start_stop)          state_d = PAUSED;
            else if (tick && at_max) state_d = DONE;
         end
         PAUSED: begin
            if (clear)           state_d = IDLE;
            else if (start_stop) state_d = RUN;
         end
         DONE:    if (clear) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // BCD ripple: each digit only moves when every lower digit is at its top value
   always_comb begin
      d0_n = d0_q + 4'd1;
      d1_n = d1_q;
      d2_n = d2_q;
      d3_n = d3_q;
      if (d0_q == 4'd9) begin
         d0_n = 4'd0;
         d1_n = d1_q + 4'd1;
         if (d1_q == 4'd9) begin
            d1_n = 4'd0;
            d2_n = d2_q + 4'd1;
            if (d2_q == 4'd5) begin
               d2_n = 4'd0;
               d3_n = d3_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else if (do_clear) begin
         presc_q <= '0;
      end else if (state_q == RUN) begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d3_q <= 4'd0;
         d2_q <= 4'd0;
         d1_q <= 4'd0;
         d0_q <= 4'd0;
      end else if (do_clear) begin
         d3_q <= 4'd0;
         d2_q <= 4'd0;
         d1_q <= 4'd0;
         d0_q <= 4'd0;
      end else if (tick && !at_max) begin
         d3_q <= d3_n;
         d2_q <= d2_n;
         d1_q <= d1_n;
         d0_q <= d0_n;
      end
   end

   assign running  = (state_q == RUN);
   assign overflow = (state_q == DONE);

`ifdef LAP_HOLD_EN
   logic        hold_q;
   logic [15:0] lap_q;

   // hold can only be set in RUN, and every way out of RUN drops it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= 1'b0;
         lap_q  <= 16'h0000;
      end else if (state_q != RUN) begin
         hold_q <= 1'b0;
      end else if (start_stop || (tick && at_max)) begin
         hold_q <= 1'b0;
      end else if (lap) begin
         hold_q <= ~hold_q;
         if (!hold_q) lap_q <= {d3_q, d2_q, d1_q, d0_q};
      end
   end

   assign {hex3, hex2, hex1, hex0} = hold_q ? lap_q : {d3_q, d2_q, d1_q, d0_q};
`else
   logic lap_unused;
   assign lap_unused = lap;

   assign {hex3, hex2, hex1, hex0} = {d3_q, d2_q, d1_q, d0_q};
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter (TICK_DIV = 4): expected values are queued by cycle, a negedge monitor compares.
module tb_stopwatch_counter;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [3:0] hex3, hex2, hex1, hex0;
   logic       running, overflow;

   stopwatch_counter #(.TICK_DIV(4), .PRESC_W(3)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .hex3       (hex3),
      .hex2       (hex2),
      .hex1       (hex1),
      .hex0       (hex0),
      .running    (running),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges seen so far
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] hex;
      logic        run;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input int c, input logic [15:0] h, input logic r, input logic o, input string n);
      exp_t x;
      x.cyc = c; x.hex = h; x.run = r; x.ovf = o; x.name = n;
      q.push_back(x);
   endtask

   always @(negedge clock) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
         end else if ({hex3, hex2, hex1, hex0, running, overflow} !== {e.hex, e.run, e.ovf}) begin
            errors++;
            $display("FAIL %s @%0d: got hex=%h run=%b ovf=%b, want hex=%h run=%b ovf=%b",
                     e.name, cyc, {hex3, hex2, hex1, hex0}, running, overflow, e.hex, e.run, e.ovf);
         end
      end
   end

   task automatic wait_edge(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // the input pulse is sampled by rising edge number t
   task automatic pulse_at(input int t, input logic ss, input logic cl, input logic lp);
      wait_edge(t - 1);
      start_stop = ss; clear = cl; lap = lp;
      @(posedge clock);
      #1;
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int drain;
      chk(1, 16'h0000, 1'b0, 1'b0, "reset_state");
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // first run from IDLE: start sampled at edge 5
      chk(40, 16'h0008, 1'b1, 1'b0, "tick8_at_35");
      chk(41, 16'h0009, 1'b1, 1'b0, "tick9_at_36");
      chk(45, 16'h0010, 1'b1, 1'b0, "one_sec_at_40");
      chk(48, 16'h0010, 1'b1, 1'b0, "clear_in_run_ignored");
      chk(50, 16'h0011, 1'b0, 1'b0, "ss_beats_clear_in_run");
      chk(55, 16'h0011, 1'b0, 1'b0, "paused_holds");
      chk(57, 16'h0000, 1'b0, 1'b0, "clear_in_paused");
      pulse_at(5, 1'b1, 1'b0, 1'b0);
      pulse_at(47, 1'b0, 1'b1, 1'b0);
      pulse_at(50, 1'b1, 1'b1, 1'b0);
      pulse_at(57, 1'b0, 1'b1, 1'b0);

      // pause at 0:00.3 with prescaler 2, resume after 100+ clocks
      chk(72, 16'h0003, 1'b1, 1'b0, "run_0003");
      chk(74, 16'h0003, 1'b0, 1'b0, "pause_0003");
      chk(174, 16'h0003, 1'b0, 1'b0, "long_pause_0003");
      chk(175, 16'h0003, 1'b1, 1'b0, "resume_running");
      chk(176, 16'h0003, 1'b1, 1'b0, "resume_plus1");
      chk(177, 16'h0004, 1'b1, 1'b0, "resume_tick_plus2");
      pulse_at(60, 1'b1, 1'b0, 1'b0);
      pulse_at(74, 1'b1, 1'b0, 1'b0);
      pulse_at(175, 1'b1, 1'b0, 1'b0);

      // count origin now edge 161: 0:59.9 -> 1:00.0, then saturate at 9:59.9
      chk(2560, 16'h0599, 1'b1, 1'b0, "at_0599");
      chk(2561, 16'h1000, 1'b1, 1'b0, "wrap_to_1000");
      chk(24160, 16'h9599, 1'b1, 1'b0, "at_9599");
      chk(24161, 16'h9599, 1'b0, 1'b1, "done_saturate");
      chk(24166, 16'h9599, 1'b0, 1'b1, "ss_ignored_in_done");
      chk(24169, 16'h0000, 1'b0, 1'b0, "clear_from_done");
      chk(24175, 16'h0000, 1'b1, 1'b0, "restart_presc_zeroed");
      chk(24176, 16'h0001, 1'b1, 1'b0, "restart_first_tick");
      pulse_at(24164, 1'b1, 1'b0, 1'b0);
      pulse_at(24169, 1'b0, 1'b1, 1'b0);
      pulse_at(24172, 1'b1, 1'b0, 1'b0);

      // lap at 0:01.2 (edge 24221), release at edge 24254
`ifdef LAP_HOLD_EN
      chk(24232, 16'h0012, 1'b1, 1'b0, "lap_hold_early");
      chk(24252, 16'h0012, 1'b1, 1'b0, "lap_hold_8_ticks");
      chk(24254, 16'h0020, 1'b1, 1'b0, "lap_release_live");
      chk(24261, 16'h0022, 1'b1, 1'b0, "live_before_reset");
      pulse_at(24221, 1'b0, 1'b0, 1'b1);
      pulse_at(24254, 1'b0, 1'b0, 1'b1);
`else
      chk(24232, 16'h0015, 1'b1, 1'b0, "lap_ignored_live");
      chk(24261, 16'h0022, 1'b1, 1'b0, "live_before_reset");
      pulse_at(24221, 1'b0, 1'b0, 1'b1);
`endif

      // asynchronous reset between edges: outputs must clear before the next rising edge
      chk(24262, 16'h0000, 1'b0, 1'b0, "async_reset_mid_count");
      chk(24265, 16'h0000, 1'b0, 1'b0, "held_in_reset");
      wait_edge(24262);
      reset_n = 1'b0;
      wait_edge(24266);
      reset_n = 1'b1;

      drain = 0;
      while (q.size() > 0 && drain < 200) begin
         @(posedge clock);
         drain++;
      end
      if (q.size() > 0) begin
         $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
         errors += q.size();
      end
      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Stopwatch timebase and BCD counter directly upstream of the 7-segment display multiplexer. Divides the 100 MHz system clock into 0.1 s ticks and counts elapsed time as M.SS.t. Drives four BCD digits: hex3 = minutes, hex2 = seconds tens, hex1 = seconds ones, hex0 = tenths. Start/stop and clear arrive as single-cycle pulses from the debounced button block.

Parameters:
TICK_DIV, 10_000_000, clock cycles per 0.1 s tick; benches override with a small value, e.g. 4.
PRESC_W, 24, prescaler width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
clock  input  1  100 MHz system clock
reset_n  input  1  asynchronous, active-low reset
start_stop  input  1  1-cycle pulse; toggles run/pause
clear  input  1  1-cycle pulse; zeroes the count when not running
lap  input  1  1-cycle pulse; toggles display hold; used only with LAP_HOLD_EN
hex3  output  4  minutes BCD, 0-9
hex2  output  4  seconds tens BCD, 0-5
hex1  output  4  seconds ones BCD, 0-9
hex0  output  4  tenths BCD, 0-9
running  output  1  high in RUN
overflow  output  1  high in DONE

Behaviour:
- Reset is asynchronous, active-low. It sets state IDLE, prescaler 0, all digits 0, running 0, overflow 0, hold 0.
- States:
  - IDLE: count 0:00.0, stopped.
  - RUN: counting.
  - PAUSED: stopped with a nonzero count.
  - DONE: saturated at 9:59.9.
- Transitions:
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSED
  - PAUSED --start_stop--> RUN
  - PAUSED or DONE --clear--> IDLE, which zeroes the digits and the prescaler
  - RUN --tick while count == 9:59.9--> DONE
- Ignored inputs:
  - clear in RUN
  - clear in IDLE (no-op)
  - start_stop in DONE
- Simultaneous start_stop and clear:
  - In RUN: start_stop wins and the block pauses.
  - In PAUSED: clear wins and the block goes to IDLE.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1.
  - tick = (prescaler == TICK_DIV-1) in RUN; prescaler returns to 0 on the same edge.
  - Prescaler holds its value in PAUSED, so elapsed time accumulates exactly across pauses.
  - Prescaler is zeroed on entry to IDLE.
- Digit chain, applied on the tick edge:
  - hex0 increments; at 9 it wraps to 0 and carries to hex1.
  - hex1 0-9 wraps with carry to hex2.
  - hex2 0-5 wraps with carry to hex3.
  - hex3 0-9.
  - The tick that would advance past 9:59.9 does not change the digits; it moves the state to DONE instead.
- Timing:
  - All outputs are registered.
  - New digits are visible one clock after the tick cycle.
  - running and overflow follow the state register with no extra delay.
- First tick after leaving IDLE arrives exactly TICK_DIV clocks after the start_stop edge.
- Digits are never outside BCD range; hex2 is never above 5.
- Reset asserted mid-count returns everything to reset values immediately and does not wait for a clock edge.

Optional Feature:
LAP_HOLD_EN.
- Defined:
  - A lap pulse in RUN toggles hold.
  - On the edge where hold is set, the current digits are captured into a lap register.
  - While hold = 1, hex3..hex0 show the lap register and the internal count keeps running.
  - Hold is cleared by:
    - a second lap pulse in RUN, after which outputs show the live count next cycle
    - a start_stop pulse, on the same edge it takes effect
    - entering DONE or IDLE
  - lap outside RUN is ignored.
  - lap and start_stop in the same cycle: start_stop wins and hold is cleared.
- Undefined:
  - The lap port is present but ignored; no lap register is synthesised.
  - hex outputs always show the live count.

Test Plan:
All scenarios use TICK_DIV = 4.
1. Reset, then start_stop pulse, then 40 clocks -> hex = 0:00.9 after 36 clocks, then 0:01.0 at clock 40; running = 1.
2. Count reaches 0:59.9, then one tick -> 1:00.0 (hex2 wraps 5->0, hex3 = 1).
3. Pause at 0:00.3 with prescaler at 2, wait 100 clocks, resume -> hex holds 0:00.3 while paused; next tick arrives 2 clocks after resume.
4. Preload the count to 9:59.9 in RUN, then tick -> DONE; overflow = 1; digits stay 9:59.9; start_stop is ignored; clear -> 0:00.0, IDLE, overflow = 0.
5. In RUN, pulse clear, then pulse start_stop and clear in the same cycle -> the first clear is ignored; the simultaneous pair gives PAUSED with the count kept; a second clear gives IDLE.
6. With LAP_HOLD_EN: lap at 0:01.2, wait 8 ticks -> hex shows 0:01.2; second lap -> hex shows 0:02.0. Assert reset_n low mid-count -> all outputs 0 immediately.
